// File: rtl/if_fetch_stage.sv
// IF stage: owns the PC, issues one inst_sram request at a time over the
// req/addr_ok/data_ok handshake, buffers one instruction while ID stalls and
// applies branch (delay-slot) and exception/ERET redirects.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        ex_flush,
    input  logic [31:0] ex_target,
    input  logic        ds_allowin,
    output logic        fs_valid,
    output logic [64:0] fs_data,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        redirect_pend_q, redirect_pend_d;
    logic        discard_q, discard_d;
    logic [64:0] hold_data_q, hold_data_d;
    // Keeps req low in the first cycle after reset release.
    logic        started_q;

    logic        req_live;
    logic        adef_live;
    logic        resp_live;
    logic        handoff;
    logic        br_accept;
    logic [31:0] next_seq_pc;

    assign req_live  = started_q && (state_q == StReq) && (pc_q[1:0] == 2'b00);
    assign adef_live = started_q && (state_q == StReq) && (pc_q[1:0] != 2'b00);
    // A response arriving together with a flush is stale and never presented.
    assign resp_live = (state_q == StWait) && inst_sram_data_ok && !discard_q && !ex_flush;
    assign handoff   = fs_valid && ds_allowin;
    // Branches cannot come from a flushed ID, so ignore them while a discard is pending.
    assign br_accept = br_taken && !discard_q;
    assign next_seq_pc = br_accept       ? br_target     :
                         redirect_pend_q ? redirect_pc_q : pc_q + 32'd4;

    assign inst_sram_addr  = pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a flush never retracts a request, so REQ only leaves on addr_ok
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq: begin
                if (req_live && inst_sram_addr_ok) state_d = StWait;
            end
            StWait: begin
                if (inst_sram_data_ok) begin
                    if (discard_q || ex_flush || ds_allowin) state_d = StReq;
                    else                                    state_d = StHold;
                end
            end
            StHold: begin
                if (ex_flush || ds_allowin) state_d = StReq;
            end
            default: state_d = StReq;
        endcase
    end

    // FSM outputs toward IF/ID and inst_sram
    always_comb begin
        fs_valid      = adef_live || resp_live || (state_q == StHold);
        inst_sram_req = req_live;
        fs_data       = 65'h0;
        if (resp_live)              fs_data = {1'b0, pc_q, inst_sram_rdata};
        else if (adef_live)         fs_data = {1'b1, pc_q, 32'h0};
        else if (state_q == StHold) fs_data = hold_data_q;
    end

    // PC, redirect bookkeeping and the stall buffer
    always_comb begin
        pc_d            = pc_q;
        redirect_pc_d   = redirect_pc_q;
        redirect_pend_d = redirect_pend_q;
        discard_d       = discard_q;
        hold_data_d     = hold_data_q;
        if (ex_flush) begin
            redirect_pend_d = 1'b0;
            unique case (state_q)
                StReq: begin
                    // Request already on the bus: park the target until its response drains.
                    if (req_live) begin
                        discard_d     = 1'b1;
                        redirect_pc_d = ex_target;
                    end else begin
                        pc_d = ex_target;
                    end
                end
                StWait: begin
                    if (inst_sram_data_ok) begin
                        discard_d = 1'b0;
                        pc_d      = ex_target;
                    end else begin
                        discard_d     = 1'b1;
                        redirect_pc_d = ex_target;
                    end
                end
                default: pc_d = ex_target;
            endcase
        end else begin
            if (br_accept) begin
                redirect_pc_d   = br_target;
                redirect_pend_d = 1'b1;
            end
            if ((state_q == StWait) && inst_sram_data_ok) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                    pc_d      = redirect_pc_q;
                end else begin
                    hold_data_d = {1'b0, pc_q, inst_sram_rdata};
                end
            end
            if (handoff) begin
                pc_d            = next_seq_pc;
                redirect_pend_d = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q            <= RESET_PC;
            redirect_pc_q   <= 32'h0;
            redirect_pend_q <= 1'b0;
            discard_q       <= 1'b0;
            hold_data_q     <= 65'h0;
            started_q       <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            redirect_pc_q   <= redirect_pc_d;
            redirect_pend_q <= redirect_pend_d;
            discard_q       <= discard_d;
            hold_data_q     <= hold_data_d;
            started_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run checked
// against a program-order model of which PC must be handed to ID next.
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        br_taken, ex_flush, ds_allowin;
    logic [31:0] br_target, ex_target;
    logic        fs_valid;
    logic [64:0] fs_data;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    // memory model state
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_acnt, mem_dcnt;
    int          amin = 0, amax = 0, dmin = 0, dmax = 0;

    // values observed in the last cycle (sampled at the falling edge)
    logic        obs_valid, obs_req, obs_aok, obs_busy;
    logic [64:0] obs_data;
    logic [31:0] obs_addr;

    if_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .ex_flush          (ex_flush),
        .ex_target         (ex_target),
        .ds_allowin        (ds_allowin),
        .fs_valid          (fs_valid),
        .fs_data           (fs_data),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (addr_ok),
        .inst_sram_data_ok (data_ok),
        .inst_sram_rdata   (rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9bdf;
    endfunction

    // One clock: memory drives its outputs, DUT is sampled at negedge, pulses are cleared.
    task automatic tick();
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        rdata    = 32'h0;
        obs_busy = mem_busy;
        if (mem_busy) begin
            if (mem_dcnt == 0) begin
                data_ok = 1'b1;
                rdata   = inst_of(mem_addr);
            end else begin
                mem_dcnt--;
            end
        end else if (inst_sram_req) begin
            if (mem_acnt == 0) addr_ok = 1'b1;
            else               mem_acnt--;
        end
        @(negedge clk);
        obs_valid = fs_valid;
        obs_data  = fs_data;
        obs_req   = inst_sram_req;
        obs_addr  = inst_sram_addr;
        obs_aok   = addr_ok;
        @(posedge clk);
        #1;
        if (data_ok) mem_busy = 1'b0;
        if (obs_req && addr_ok) begin
            mem_busy = 1'b1;
            mem_addr = obs_addr;
            mem_dcnt = $urandom_range(dmax, dmin);
            mem_acnt = $urandom_range(amax, amin);
        end
        br_taken = 1'b0;
        ex_flush = 1'b0;
    endtask

    // Reset, then step through the release cycle; next tick is the first request.
    task automatic do_reset();
        resetn     = 1'b0;
        br_taken   = 1'b0;
        ex_flush   = 1'b0;
        ds_allowin = 1'b1;
        mem_busy   = 1'b0;
        mem_acnt   = $urandom_range(amax, amin);
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        amin = 0; amax = 0; dmin = 0; dmax = 0;
        resetn = 1'b0; br_taken = 1'b0; ex_flush = 1'b0; ds_allowin = 1'b1;
        br_target = 32'h0; ex_target = 32'h0; mem_busy = 1'b0; mem_acnt = 0;
        tick();
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", obs_valid); end
        total++; if (obs_data !== 65'h0) begin bad++; $display("FAIL reset_data got=%h want=0", obs_data); end
        total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", obs_req); end
        resetn = 1'b1;
        tick();
        total++; if (obs_req !== 1'b0) begin bad++; $display("FAIL release_req got=%b want=0", obs_req); end
        tick();
        total++;
        if (obs_req !== 1'b1 || obs_addr !== RST_PC) begin
            bad++; $display("FAIL first_req got=%b/%h want=1/%h", obs_req, obs_addr, RST_PC);
        end
        total++;
        if (inst_sram_wr !== 1'b0 || inst_sram_size !== 2'd2 || inst_sram_wstrb !== 4'h0 ||
            inst_sram_wdata !== 32'h0) begin
            bad++; $display("FAIL tie_offs got=%b/%h/%h/%h want=0/2/0/0", inst_sram_wr,
                            inst_sram_size, inst_sram_wstrb, inst_sram_wdata);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        amin = 0; amax = 0; dmin = 0; dmax = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            a = RST_PC + 32'(4 * (i / 2));
            total++;
            if (obs_valid !== (i % 2 == 1)) begin
                bad++; $display("FAIL seq_valid[%0d] got=%b want=%b", i, obs_valid, (i % 2 == 1));
            end
            if (i % 2 == 0) begin
                total++;
                if (obs_req !== 1'b1 || obs_addr !== a) begin
                    bad++; $display("FAIL seq_addr[%0d] got=%b/%h want=1/%h", i, obs_req, obs_addr, a);
                end
            end else begin
                total++;
                if (obs_data !== {1'b0, a, inst_of(a)}) begin
                    bad++; $display("FAIL seq_data[%0d] got=%h want=%h", i, obs_data, {1'b0, a, inst_of(a)});
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [64:0] exp;
        amin = 0; amax = 0; dmin = 0; dmax = 0;
        do_reset();
        tick();
        exp = {1'b0, RST_PC, inst_of(RST_PC)};
        ds_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs_valid !== 1'b1 || obs_data !== exp || obs_req !== 1'b0) begin
                bad++; $display("FAIL stall_hold[%0d] got=%b/%h/%b want=1/%h/0", i, obs_valid,
                                obs_data, obs_req, exp);
            end
        end
        ds_allowin = 1'b1;
        tick();
        total++;
        if (obs_valid !== 1'b1 || obs_data !== exp) begin
            bad++; $display("FAIL stall_release got=%b/%h want=1/%h", obs_valid, obs_data, exp);
        end
        tick();
        total++;
        if (obs_req !== 1'b1 || obs_addr !== RST_PC + 32'd4) begin
            bad++; $display("FAIL stall_next_req got=%b/%h want=1/%h", obs_req, obs_addr, RST_PC + 32'd4);
        end
    endtask

    task automatic test_branch();
        amin = 0; amax = 0; dmin = 0; dmax = 0;
        do_reset();
        tick();
        tick();
        br_taken = 1'b1; br_target = 32'hbfc0_0100;
        tick();
        total++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hbfc0_0004) begin
            bad++; $display("FAIL br_ds_req got=%b/%h want=1/bfc00004", obs_req, obs_addr);
        end
        tick();
        total++;
        if (obs_valid !== 1'b1 || obs_data !== {1'b0, 32'hbfc0_0004, inst_of(32'hbfc0_0004)}) begin
            bad++; $display("FAIL br_delay_slot got=%b/%h want=1/%h", obs_valid, obs_data,
                            {1'b0, 32'hbfc0_0004, inst_of(32'hbfc0_0004)});
        end
        tick();
        total++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hbfc0_0100) begin
            bad++; $display("FAIL br_target_req got=%b/%h want=1/bfc00100", obs_req, obs_addr);
        end
    endtask

    task automatic test_flush_wait();
        amin = 0; amax = 0; dmin = 2; dmax = 2;
        do_reset();
        tick();
        ex_flush = 1'b1; ex_target = 32'hbfc0_0380;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs_valid !== 1'b0 || obs_req !== 1'b0) begin
                bad++; $display("FAIL fw_drop[%0d] got=%b/%b want=0/0", i, obs_valid, obs_req);
            end
        end
        tick();
        total++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hbfc0_0380) begin
            bad++; $display("FAIL fw_next_req got=%b/%h want=1/bfc00380", obs_req, obs_addr);
        end
        // flush arriving together with data_ok
        dmin = 0; dmax = 0;
        do_reset();
        tick();
        ex_flush = 1'b1; ex_target = 32'hbfc0_0380;
        tick();
        total++;
        if (obs_valid !== 1'b0) begin bad++; $display("FAIL fw_same_cycle got=%b want=0", obs_valid); end
        tick();
        total++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hbfc0_0380) begin
            bad++; $display("FAIL fw_same_next got=%b/%h want=1/bfc00380", obs_req, obs_addr);
        end
    endtask

    task automatic test_flush_req();
        amin = 3; amax = 3; dmin = 0; dmax = 0;
        do_reset();
        ex_flush = 1'b1; ex_target = 32'hbfc0_0380;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (obs_req !== 1'b1 || obs_addr !== RST_PC || obs_aok !== (i == 3)) begin
                bad++; $display("FAIL fr_held[%0d] got=%b/%h/%b want=1/%h/%b", i, obs_req, obs_addr,
                                obs_aok, RST_PC, (i == 3));
            end
        end
        tick();
        total++;
        if (obs_valid !== 1'b0) begin bad++; $display("FAIL fr_discard got=%b want=0", obs_valid); end
        tick();
        total++;
        if (obs_req !== 1'b1 || obs_addr !== 32'hbfc0_0380) begin
            bad++; $display("FAIL fr_next_req got=%b/%h want=1/bfc00380", obs_req, obs_addr);
        end
    endtask

    task automatic test_adef();
        amin = 0; amax = 0; dmin = 0; dmax = 0;
        do_reset();
        tick();
        tick();
        br_taken = 1'b1; br_target = 32'hbfc0_0102;
        tick();
        tick();
        ds_allowin = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_data !== {1'b1, 32'hbfc0_0102, 32'h0}) begin
                bad++; $display("FAIL adef_present[%0d] got=%b/%b/%h want=0/1/%h", i, obs_req,
                                obs_valid, obs_data, {1'b1, 32'hbfc0_0102, 32'h0});
            end
        end
        ds_allowin = 1'b1;
        tick();
        tick();
        total++;
        if (obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_data !== {1'b1, 32'hbfc0_0106, 32'h0}) begin
            bad++; $display("FAIL adef_advance got=%b/%b/%h want=0/1/%h", obs_req, obs_valid,
                            obs_data, {1'b1, 32'hbfc0_0106, 32'h0});
        end
    endtask

    task automatic test_reset_mid();
        amin = 3; amax = 3; dmin = 0; dmax = 0;
        do_reset();
        ex_flush = 1'b1; ex_target = 32'hbfc0_0380;
        tick();
        tick();
        resetn = 1'b0;
        #2;
        total++;
        if (fs_valid !== 1'b0 || inst_sram_req !== 1'b0) begin
            bad++; $display("FAIL mid_reset_async got=%b/%b want=0/0", fs_valid, inst_sram_req);
        end
        mem_busy = 1'b0;
        amin = 0; amax = 0; mem_acnt = 0;
        tick();
        resetn = 1'b1;
        tick();
        tick();
        total++;
        if (obs_req !== 1'b1 || obs_addr !== RST_PC) begin
            bad++; $display("FAIL mid_reset_req got=%b/%h want=1/%h", obs_req, obs_addr, RST_PC);
        end
        tick();
        total++;
        if (obs_valid !== 1'b1 || obs_data !== {1'b0, RST_PC, inst_of(RST_PC)}) begin
            bad++; $display("FAIL mid_reset_no_discard got=%b/%h want=1/%h", obs_valid, obs_data,
                            {1'b0, RST_PC, inst_of(RST_PC)});
        end
    endtask

    // Random run: the model tracks only the program-order PC ID must receive next.
    task automatic test_random();
        logic [31:0] exp_pc, pend_tgt, prev_addr;
        logic [64:0] exp;
        bit          pend, seen, br, fl, prev_req, prev_aok;
        int          idle;
        amin = 0; amax = 2; dmin = 0; dmax = 3;
        do_reset();
        exp_pc = RST_PC; pend = 0; seen = 0; idle = 0;
        prev_req = 0; prev_aok = 0; prev_addr = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            ds_allowin = ($urandom_range(3, 0) != 0);
            fl = ($urandom_range(39, 0) == 0);
            br = !fl && seen && !pend && ($urandom_range(5, 0) == 0);
            ex_flush  = fl;
            ex_target = {16'hbfc0, 16'($urandom_range(65535, 0)) & 16'hfffc};
            br_taken  = br;
            br_target = {16'hbfc0, 16'($urandom_range(65535, 0))};
            if ($urandom_range(7, 0) != 0) br_target[1:0] = 2'b00;
            tick();
            if (prev_req && !prev_aok) begin
                total++;
                if (obs_req !== 1'b1 || obs_addr !== prev_addr) begin
                    bad++; $display("FAIL rnd_req_stable[%0d] got=%b/%h want=1/%h", i, obs_req,
                                    obs_addr, prev_addr);
                end
            end
            if (obs_req) begin
                total++;
                if (obs_busy !== 1'b0) begin
                    bad++; $display("FAIL rnd_one_outstanding[%0d] got=busy want=idle", i);
                end
            end
            if (fl) begin
                exp_pc = ex_target; pend = 0; seen = 0; idle = 0;
            end else if (obs_valid && ds_allowin) begin
                exp = (exp_pc[1:0] != 2'b00) ? {1'b1, exp_pc, 32'h0} : {1'b0, exp_pc, inst_of(exp_pc)};
                total++;
                if (obs_data !== exp) begin
                    bad++; $display("FAIL rnd_handoff[%0d] got=%h want=%h", i, obs_data, exp);
                end
                if (br) exp_pc = br_target;
                else if (pend) begin exp_pc = pend_tgt; pend = 0; end
                else exp_pc = exp_pc + 32'd4;
                seen = 1; idle = 0;
            end else begin
                if (br) begin pend = 1; pend_tgt = br_target; end
                idle++;
            end
            if (idle > 80) begin
                total++; bad++;
                $display("FAIL rnd_progress[%0d] got=%0d idle cycles want<=80", i, idle);
                break;
            end
            prev_req = obs_req; prev_aok = obs_aok; prev_addr = obs_addr;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_flush_wait();
        test_flush_req();
        test_adef();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
